// File: rtl/surf_i2c_arbiter.sv
// surf_i2c_arbiter
// Round-robin WISHBONE arbiter that lets NUM_MASTERS requesters share the
// single 8-bit I2C core port on the SURF RF-power board. A granted master
// may keep the bus across several transfers with m_lock_i. Each transfer
// phase and each lock-hold phase is limited to TIMEOUT_CYCLES cycles. All
// outputs are registered.
//
// Ports
//   wbc_clk_i, wbc_rst_i : clock, asynchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i/m_lock_i : per-master WISHBONE control, one bit per master
//   m_adr_i/m_dat_i      : packed per-master address / write data (master k at k*W +: W)
//   m_dat_o              : shared read data, valid with m_ack_o
//   m_ack_o/m_err_o      : one-cycle acknowledge / timeout pulses to the owner
//   gnt_o                : one-hot current owner, 0 when idle
//   i2c_cyc_o/i2c_stb_o/i2c_we_o/i2c_adr_o/i2c_dat_o : slave-side request
//   i2c_dat_i/i2c_ack_i  : slave-side response
module surf_i2c_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADR_WIDTH      = 7,
  parameter int DAT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           wbc_clk_i,
  input  logic                           wbc_rst_i,
  input  logic [NUM_MASTERS-1:0]         m_cyc_i,
  input  logic [NUM_MASTERS-1:0]         m_stb_i,
  input  logic [NUM_MASTERS-1:0]         m_we_i,
  input  logic [NUM_MASTERS-1:0]         m_lock_i,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_dat_i,
  output logic [DAT_WIDTH-1:0]           m_dat_o,
  output logic [NUM_MASTERS-1:0]         m_ack_o,
  output logic [NUM_MASTERS-1:0]         m_err_o,
  output logic [NUM_MASTERS-1:0]         gnt_o,
  output logic                           i2c_cyc_o,
  output logic                           i2c_stb_o,
  output logic                           i2c_we_o,
  output logic [ADR_WIDTH-1:0]           i2c_adr_o,
  output logic [DAT_WIDTH-1:0]           i2c_dat_o,
  input  logic [DAT_WIDTH-1:0]           i2c_dat_i,
  input  logic                           i2c_ack_i
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
  localparam logic [GW-1:0] LAST_RESET = GW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, XFER, ACK, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          lastGnt_q, lastGnt_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;
  logic [DAT_WIDTH-1:0]   rdat_q, rdat_d;
  logic [DAT_WIDTH-1:0]   wdat_q, wdat_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic                   cyc_q, cyc_d;
  logic                   stb_q, stb_d;
  logic                   we_q, we_d;

  // Unpack the per-master buses so the request mux is a plain array index.
  logic [ADR_WIDTH-1:0] adrArr [NUM_MASTERS];
  logic [DAT_WIDTH-1:0] datArr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign adrArr[k] = m_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
    assign datArr[k] = m_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
  end

  // Round-robin search: start one past the last owner and take the first
  // master with both cyc and stb, wrapping modulo NUM_MASTERS.
  logic          found;
  logic [GW-1:0] winIdx;
  logic [GW-1:0] candIdx;

  always_comb begin
    found   = 1'b0;
    winIdx  = lastGnt_q;
    candIdx = lastGnt_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      candIdx = GW'((int'(lastGnt_q) + i) % NUM_MASTERS);
      if (!found && m_cyc_i[candIdx] && m_stb_i[candIdx]) begin
        found  = 1'b1;
        winIdx = candIdx;
      end
    end
  end

  // lastGnt_q doubles as the owner index while a grant is active.
  logic          ownCyc, ownStb, ownLock, timerLast;
  logic [TW-1:0] timerInc;

  assign ownCyc    = m_cyc_i[lastGnt_q];
  assign ownStb    = m_stb_i[lastGnt_q];
  assign ownLock   = m_lock_i[lastGnt_q];
  assign timerLast = (timer_q == TIMER_LAST);
  assign timerInc  = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;

  // Next-state logic. Ack/err are single-cycle pulses, so they default to 0
  // every cycle; everything else holds unless a transition changes it.
  always_comb begin
    state_d   = state_q;
    lastGnt_d = lastGnt_q;
    timer_d   = timer_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    err_d     = '0;
    rdat_d    = rdat_q;
    wdat_d    = wdat_q;
    adr_d     = adr_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d         = '0;
          gnt_d[winIdx] = 1'b1;
          lastGnt_d     = winIdx;
          we_d          = m_we_i[winIdx];
          adr_d         = adrArr[winIdx];
          wdat_d        = datArr[winIdx];
          cyc_d         = 1'b1;
          stb_d         = 1'b1;
          timer_d       = '0;
          state_d       = XFER;
        end
      end

      XFER: begin
        // Ack has priority: a completed transfer is never reported as aborted.
        if (i2c_ack_i) begin
          stb_d            = 1'b0;
          ack_d[lastGnt_q] = 1'b1;
          rdat_d           = i2c_dat_i;
          state_d          = ACK;
        end else if (!ownCyc) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          gnt_d   = '0;
          state_d = IDLE;
        end else if (timerLast) begin
          err_d[lastGnt_q] = 1'b1;
          cyc_d            = 1'b0;
          stb_d            = 1'b0;
          gnt_d            = '0;
          state_d          = IDLE;
        end else begin
          timer_d = timerInc;
        end
      end

      // Strobes are deliberately ignored here so a classic master has a
      // cycle to retract stb after its ack.
      ACK: begin
        if (ownLock && ownCyc) begin
          timer_d = '0;
          state_d = HOLD;
        end else begin
          cyc_d   = 1'b0;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end

      // Bus kept for the locked owner; cyc stays high, nobody else is heard.
      HOLD: begin
        if (ownCyc && ownStb) begin
          we_d    = m_we_i[lastGnt_q];
          adr_d   = adrArr[lastGnt_q];
          wdat_d  = datArr[lastGnt_q];
          stb_d   = 1'b1;
          timer_d = '0;
          state_d = XFER;
        end else if (!ownLock || !ownCyc || timerLast) begin
          cyc_d   = 1'b0;
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          timer_d = timerInc;
        end
      end

      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset parks the pointer on the last
  // master so master 0 is searched first.
  always_ff @(posedge wbc_clk_i or posedge wbc_rst_i) begin
    if (wbc_rst_i) begin
      state_q   <= IDLE;
      lastGnt_q <= LAST_RESET;
      timer_q   <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rdat_q    <= '0;
      wdat_q    <= '0;
      adr_q     <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lastGnt_q <= lastGnt_d;
      timer_q   <= timer_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdat_q    <= rdat_d;
      wdat_q    <= wdat_d;
      adr_q     <= adr_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
    end
  end

  assign m_dat_o   = rdat_q;
  assign m_ack_o   = ack_q;
  assign m_err_o   = err_q;
  assign gnt_o     = gnt_q;
  assign i2c_cyc_o = cyc_q;
  assign i2c_stb_o = stb_q;
  assign i2c_we_o  = we_q;
  assign i2c_adr_o = adr_q;
  assign i2c_dat_o = wdat_q;

endmodule

// File: tb/tb_surf_i2c_arbiter.sv
// tb_surf_i2c_arbiter
// Bench for surf_i2c_arbiter with three masters and a 16-cycle timeout.
// A transaction-level model predicts every output; directed scenarios add
// hand-computed expectations, then a long randomized run exercises traffic.
module tb_surf_i2c_arbiter;

  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int T  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]    tbCyc, tbStb, tbWe, tbLock;
  logic [AW-1:0]   tbAdr [N];
  logic [DW-1:0]   tbDat [N];
  logic [N*AW-1:0] adrBus;
  logic [N*DW-1:0] datBus;

  logic [DW-1:0] m_dat_o;
  logic [N-1:0]  m_ack_o, m_err_o, gnt_o;
  logic          i2c_cyc_o, i2c_stb_o, i2c_we_o;
  logic [AW-1:0] i2c_adr_o;
  logic [DW-1:0] i2c_dat_o;
  logic [DW-1:0] i2c_dat_i = '0;
  logic          i2c_ack_i = 1'b0;

  int nCompared = 0;
  int nFailed   = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign adrBus[g*AW +: AW] = tbAdr[g];
    assign datBus[g*DW +: DW] = tbDat[g];
  end

  surf_i2c_arbiter #(
    .NUM_MASTERS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .wbc_clk_i(clk), .wbc_rst_i(rst),
    .m_cyc_i(tbCyc), .m_stb_i(tbStb), .m_we_i(tbWe), .m_lock_i(tbLock),
    .m_adr_i(adrBus), .m_dat_i(datBus),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .gnt_o(gnt_o),
    .i2c_cyc_o(i2c_cyc_o), .i2c_stb_o(i2c_stb_o), .i2c_we_o(i2c_we_o),
    .i2c_adr_o(i2c_adr_o), .i2c_dat_o(i2c_dat_o),
    .i2c_dat_i(i2c_dat_i), .i2c_ack_i(i2c_ack_i)
  );

  always #5 clk = ~clk;

  // One comparison: counts, and reports a FAIL line on disagreement.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int k, input bit cyc, input bit stb, input bit we,
                               input bit lock, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    tbCyc[k]  = cyc;
    tbStb[k]  = stb;
    tbWe[k]   = we;
    tbLock[k] = lock;
    tbAdr[k]  = adr;
    tbDat[k]  = dat;
  endtask

  // Slave responder: directed mode acks after a fixed number of strobe
  // cycles (0 = never); random mode acks at random with deaf stretches.
  bit          slaveRandom = 1'b0;
  bit          slaveDeaf   = 1'b0;
  int          ackDelay    = 1;
  int          stbRun      = 0;
  logic [DW-1:0] dirData   = '0;

  always @(negedge clk) begin
    if (slaveRandom) begin
      if ($urandom_range(63) == 0) slaveDeaf = !slaveDeaf;
      if (i2c_stb_o) i2c_ack_i = !slaveDeaf && ($urandom_range(2) == 0);
      else           i2c_ack_i = ($urandom_range(9) == 0);
      i2c_dat_i = DW'($urandom);
    end else begin
      if (i2c_stb_o) stbRun++;
      else           stbRun = 0;
      i2c_ack_i = i2c_stb_o && (ackDelay != 0) && (stbRun >= ackDelay);
      i2c_dat_i = dirData;
    end
  end

  // Transaction-level model: owner (-1 when free), what the bus is doing
  // (0 free, 1 request outstanding, 2 just acknowledged, 3 held by lock),
  // and how many cycles the current request or hold has lasted.
  int            mOwner, mLast, mPhase, mWaited;
  logic [N-1:0]  eGnt, eAck, eErr;
  logic [DW-1:0] eDat, eWdat;
  logic [AW-1:0] eAdr;
  logic          eCyc, eStb, eWe;

  function automatic int rrPick();
    for (int k = 1; k <= N; k++) begin
      if (tbCyc[(mLast + k) % N] && tbStb[(mLast + k) % N]) return (mLast + k) % N;
    end
    return -1;
  endfunction

  task automatic modelLatch(input int c);
    eWe   = tbWe[c];
    eAdr  = tbAdr[c];
    eWdat = tbDat[c];
    eStb  = 1'b1;
    mWaited = 1;
    mPhase  = 1;
  endtask

  task automatic modelRelease();
    eCyc   = 1'b0;
    eStb   = 1'b0;
    eGnt   = '0;
    mOwner = -1;
    mPhase = 0;
  endtask

  task automatic modelReset();
    mOwner = -1; mLast = N - 1; mPhase = 0; mWaited = 0;
    eGnt = '0; eAck = '0; eErr = '0; eDat = '0; eWdat = '0;
    eAdr = '0; eCyc = 1'b0; eStb = 1'b0; eWe = 1'b0;
  endtask

  task automatic modelStep();
    int pick;
    eAck = '0;
    eErr = '0;
    case (mPhase)
      0: begin
        pick = rrPick();
        if (pick >= 0) begin
          mOwner = pick;
          mLast  = pick;
          eGnt   = '0;
          eGnt[pick] = 1'b1;
          eCyc   = 1'b1;
          modelLatch(pick);
        end
      end
      1: begin
        if (i2c_ack_i) begin
          eStb = 1'b0;
          eAck[mOwner] = 1'b1;
          eDat = i2c_dat_i;
          mPhase = 2;
        end else if (!tbCyc[mOwner]) begin
          modelRelease();
        end else if (mWaited == T) begin
          eErr[mOwner] = 1'b1;
          modelRelease();
        end else begin
          mWaited++;
        end
      end
      2: begin
        if (tbLock[mOwner] && tbCyc[mOwner]) begin
          mPhase  = 3;
          mWaited = 1;
        end else begin
          modelRelease();
        end
      end
      default: begin
        if (tbCyc[mOwner] && tbStb[mOwner]) modelLatch(mOwner);
        else if (!tbLock[mOwner] || !tbCyc[mOwner] || mWaited == T) modelRelease();
        else mWaited++;
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else     modelStep();
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("mdl_gnt",  32'(gnt_o),   32'(eGnt));
      checkOutput("mdl_ack",  32'(m_ack_o), 32'(eAck));
      checkOutput("mdl_err",  32'(m_err_o), 32'(eErr));
      checkOutput("mdl_rdat", 32'(m_dat_o), 32'(eDat));
      checkOutput("mdl_ctl",  32'({i2c_cyc_o, i2c_stb_o, i2c_we_o}), 32'({eCyc, eStb, eWe}));
      checkOutput("mdl_adr",  32'(i2c_adr_o), 32'(eAdr));
      checkOutput("mdl_wdat", 32'(i2c_dat_o), 32'(eWdat));
    end
  end

  task automatic idleMasters();
    for (int k = 0; k < N; k++) applyStimulus(k, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic doReset();
    @(negedge clk);
    idleMasters();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int grants[$];
    logic [N-1:0] prevG;
    int bad, acks, cycLow, early0, stbHigh, ackSeen;
    logic [N-1:0] errV, firstGnt;

    idleMasters();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", 32'({m_ack_o, m_err_o, gnt_o, i2c_cyc_o, i2c_stb_o, i2c_we_o}), 32'h0);
    checkOutput("reset_data", 32'({m_dat_o, i2c_dat_o, i2c_adr_o}), 32'h0);
    rst = 1'b0;

    // Single read, slave acks on the third strobe cycle with 0xA5.
    $display("[TB] single read");
    slaveRandom = 1'b0; ackDelay = 3; dirData = 8'hA5;
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 0, 7'h12, 8'h00);
    @(negedge clk);
    checkOutput("rd_gnt", 32'(gnt_o), 32'h1);
    checkOutput("rd_adr", 32'(i2c_adr_o), 32'h12);
    checkOutput("rd_we_stb", 32'({i2c_we_o, i2c_stb_o}), 32'b01);
    repeat (2) @(negedge clk);
    checkOutput("rd_no_early_ack", 32'(m_ack_o), 32'h0);
    @(negedge clk);
    checkOutput("rd_ack", 32'(m_ack_o), 32'h1);
    checkOutput("rd_dat", 32'(m_dat_o), 32'hA5);
    checkOutput("rd_cyc_stb_in_ack", 32'({i2c_cyc_o, i2c_stb_o}), 32'b10);
    applyStimulus(0, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("rd_release", 32'({i2c_cyc_o, m_ack_o}), 32'h0);

    // Round robin between masters 0 and 1.
    $display("[TB] round robin");
    doReset();
    ackDelay = 1;
    applyStimulus(0, 1, 1, 0, 0, 7'h01, 8'h00);
    applyStimulus(1, 1, 1, 0, 0, 7'h02, 8'h00);
    prevG = '0; bad = 0;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      @(negedge clk);
      if (gnt_o != 0 && prevG == 0) grants.push_back(int'(gnt_o));
      if ($countones(gnt_o) > 1) bad++;
      prevG = gnt_o;
    end
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("rr_grant%0d", k), 32'((k < grants.size()) ? grants[k] : 0),
                  32'((k % 2 == 0) ? 1 : 2));
    checkOutput("rr_onehot", 32'(bad), 32'h0);

    // Lock: master 1 writes 1,2,3 to 0x40 while master 0 waits.
    $display("[TB] lock");
    doReset();
    applyStimulus(1, 1, 1, 1, 1, 7'h40, 8'h01);
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 0, 7'h00, 8'h00);
    acks = 0; cycLow = 0; early0 = 0;
    for (int c = 0; c < 60 && acks < 3; c++) begin
      if (!i2c_cyc_o) cycLow++;
      if (gnt_o[0]) early0++;
      if (m_ack_o[1]) begin
        acks++;
        checkOutput($sformatf("lock_wdat%0d", acks), 32'(i2c_dat_o), 32'(acks));
        checkOutput("lock_adr_we", 32'({i2c_we_o, i2c_adr_o}), 32'({1'b1, 7'h40}));
        if (acks < 3) tbDat[1] = DW'(acks + 1);
        else applyStimulus(1, 0, 0, 0, 0, '0, '0);
      end
      if (acks < 3) @(negedge clk);
    end
    checkOutput("lock_acks", 32'(acks), 32'h3);
    checkOutput("lock_cyc_low", 32'(cycLow), 32'h0);
    checkOutput("lock_early_m0", 32'(early0), 32'h0);
    firstGnt = '0;
    for (int c = 0; c < 10 && firstGnt == 0; c++) begin
      @(negedge clk);
      firstGnt = gnt_o;
    end
    checkOutput("lock_handover", 32'(firstGnt), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, '0, '0);

    // Timeout with a slave that never answers.
    $display("[TB] timeout");
    doReset();
    ackDelay = 0;
    applyStimulus(0, 1, 1, 0, 0, 7'h21, 8'h00);
    stbHigh = 0; ackSeen = 0; errV = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (i2c_stb_o) stbHigh++;
      if (m_ack_o != 0) ackSeen++;
      if (m_err_o != 0) begin
        errV = m_err_o;
        checkOutput("to_bus_dropped", 32'({i2c_cyc_o, i2c_stb_o, gnt_o}), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, '0, '0);
        break;
      end
    end
    checkOutput("to_stb_cycles", 32'(stbHigh), 32'd16);
    checkOutput("to_err", 32'(errV), 32'h1);
    checkOutput("to_no_ack", 32'(ackSeen), 32'h0);
    @(negedge clk);
    checkOutput("to_err_one_cycle", 32'({m_err_o, gnt_o}), 32'h0);

    // Abort: owner drops cyc mid-transfer, the other master follows.
    $display("[TB] abort");
    doReset();
    applyStimulus(0, 1, 1, 1, 0, 7'h33, 8'h44);
    applyStimulus(1, 1, 1, 0, 0, 7'h55, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("ab_owner", 32'(gnt_o), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("ab_dropped", 32'({i2c_cyc_o, i2c_stb_o, gnt_o}), 32'h0);
    checkOutput("ab_no_ack_err", 32'({m_ack_o, m_err_o}), 32'h0);
    @(negedge clk);
    checkOutput("ab_next_gnt", 32'(gnt_o), 32'h2);
    checkOutput("ab_next_adr", 32'(i2c_adr_o), 32'h55);
    applyStimulus(1, 0, 0, 0, 0, '0, '0);

    // Asynchronous reset while master 0 owns the bus.
    $display("[TB] reset mid-transfer");
    doReset();
    applyStimulus(0, 1, 1, 1, 0, 7'h0F, 8'h77);
    @(negedge clk);
    checkOutput("rst_owner", 32'({gnt_o, i2c_stb_o}), 32'({3'b001, 1'b1}));
    applyStimulus(1, 1, 1, 0, 0, 7'h10, 8'h00);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_ctl", 32'({m_ack_o, m_err_o, gnt_o, i2c_cyc_o, i2c_stb_o, i2c_we_o}), 32'h0);
    checkOutput("rst_async_data", 32'({m_dat_o, i2c_dat_o, i2c_adr_o}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_priority_m0", 32'(gnt_o), 32'h1);
    idleMasters();
    repeat (3) @(negedge clk);

    // Randomized traffic; the model checks every cycle.
    $display("[TB] random traffic");
    doReset();
    slaveRandom = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        if (tbCyc[k]) begin
          if ($urandom_range(19) == 0) begin
            tbCyc[k] = 1'b0; tbStb[k] = 1'b0; tbLock[k] = 1'b0;
          end else begin
            if ($urandom_range(5) == 0) tbStb[k] = !tbStb[k];
            if ($urandom_range(7) == 0) tbLock[k] = !tbLock[k];
          end
        end else if ($urandom_range(3) == 0) begin
          tbCyc[k]  = 1'b1;
          tbStb[k]  = 1'b1;
          tbLock[k] = ($urandom_range(2) == 0);
        end
        tbWe[k]  = 1'($urandom);
        tbAdr[k] = AW'($urandom);
        tbDat[k] = DW'($urandom);
      end
    end
    idleMasters();
    slaveRandom = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
